// File: rtl/handshake_pkg.sv
// Shared definitions for the constant-sequence handshake block.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
package handshake_pkg;

    // Index behaviour after the last table entry
    localparam int WRAP_OFF = 0;  // saturate at DEPTH-1
    localparam int WRAP_ON  = 1;  // roll over to entry 0

    // Width of the table index; a one-entry table still gets a 1-bit index
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/handshake_skid_buffer.sv
// Two-entry skid buffer (main + skid register) for a valid/ready token stream.
// Latency: 1 cycle from accept to out_vld when empty; one token per cycle sustained.
// Backpressure: in_rdy is a register (= not skid-full), no combinational path from out_rdy or in_vld.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-low reset
//   in_vld/in_rdy/in_dat  upstream token (in_vld must already be qualified by the caller or is ANDed here)
//   out_vld/out_rdy/out_dat downstream token; out_dat is the main register
module handshake_skid_buffer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DATA_WIDTH-1:0] in_dat,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_dat
);

    logic                  main_vld, main_vld_d;
    logic [DATA_WIDTH-1:0] main_dat, main_dat_d;
    logic                  skid_vld, skid_vld_d;
    logic [DATA_WIDTH-1:0] skid_dat, skid_dat_d;
    logic                  rdy_q;
    logic                  acc;
    logic                  xfer;

    assign acc     = in_vld & rdy_q;
    assign xfer    = main_vld & out_rdy;
    assign in_rdy  = rdy_q;
    assign out_vld = main_vld;
    assign out_dat = main_dat;

    always_comb begin
        main_vld_d = main_vld;
        main_dat_d = main_dat;
        skid_vld_d = skid_vld;
        skid_dat_d = skid_dat;
        if (skid_vld) begin
            // Skid full means rdy_q is low, so nothing new arrives; refill main on transfer.
            if (xfer) begin
                main_dat_d = skid_dat;
                skid_vld_d = 1'b0;
            end
        end else if (main_vld) begin
            if (acc && xfer) begin
                // Leaving and arriving together: occupancy stays at one.
                main_dat_d = in_dat;
            end else if (acc) begin
                skid_vld_d = 1'b1;
                skid_dat_d = in_dat;
            end else if (xfer) begin
                // Data is left in place so out_dat holds its last value while idle.
                main_vld_d = 1'b0;
            end
        end else if (acc) begin
            main_vld_d = 1'b1;
            main_dat_d = in_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            main_vld <= 1'b0;
            main_dat <= '0;
            skid_vld <= 1'b0;
            skid_dat <= '0;
            rdy_q    <= 1'b1;
        end else begin
            main_vld <= main_vld_d;
            main_dat <= main_dat_d;
            skid_vld <= skid_vld_d;
            skid_dat <= skid_dat_d;
            rdy_q    <= ~skid_vld_d;
        end
    end

endmodule

// File: rtl/handshake_constant_seq.sv
// Emits one token per accepted trigger, carrying the next constant from a parameter table.
// Latency: 1 cycle from trigger accept to outs_valid (buffer empty); one token per cycle.
// Backpressure: two-entry skid buffer; ctrl_ready drops only when the skid slot is full.
//
// Ports:
//   clk, rst                          rising-edge clock, synchronous active-low reset
//   ctrl_valid/ctrl_ready             trigger token handshake
//   seq_clear                         restart table index at entry 0
//   outs/outs_valid/outs_ready        output token handshake
//   seq_idx                           table index the next accepted trigger will use
module handshake_constant_seq
    import handshake_pkg::*;
#(
    parameter int                            DATA_WIDTH = 32,
    parameter int                            DEPTH      = 4,
    parameter logic [DEPTH*DATA_WIDTH-1:0]   CONSTS     = '0,
    parameter int                            WRAP       = WRAP_ON
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ctrl_valid,
    output logic                          ctrl_ready,
    input  logic                          seq_clear,
    output logic [DATA_WIDTH-1:0]         outs,
    output logic                          outs_valid,
    input  logic                          outs_ready,
    output logic [idx_width(DEPTH)-1:0]   seq_idx
);

    localparam int             IDXW = idx_width(DEPTH);
    localparam logic [IDXW-1:0] LAST = IDXW'(DEPTH - 1);

    logic                  buf_rdy;
    logic                  accept;
    logic [IDXW-1:0]       idx_q;
    logic [IDXW-1:0]       use_idx;
    logic [IDXW-1:0]       inc_idx;
    logic [IDXW-1:0]       idx_d;
    logic [DATA_WIDTH-1:0] tok_dat;

    // Gating with rst keeps a producer from seeing a handshake that reset will discard.
    assign ctrl_ready = buf_rdy & rst;
    assign accept     = ctrl_valid & ctrl_ready;

    // A clear in the accept cycle makes that trigger use entry 0.
    assign use_idx = seq_clear ? '0 : idx_q;

    always_comb begin
        tok_dat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (use_idx == IDXW'(i)) begin
                tok_dat = CONSTS[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        if (use_idx == LAST) begin
            inc_idx = (WRAP == WRAP_ON) ? '0 : LAST;
        end else begin
            inc_idx = use_idx + IDXW'(1);
        end
        idx_d = accept ? inc_idx : use_idx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign seq_idx = idx_q;

    handshake_skid_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .in_vld (accept),
        .in_rdy (buf_rdy),
        .in_dat (tok_dat),
        .out_vld(outs_valid),
        .out_rdy(outs_ready),
        .out_dat(outs)
    );

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Directed bench for handshake_constant_seq: wrap table, saturating table, single-entry table.
// Latency: n/a.
// Backpressure: n/a.
module tb_handshake_constant_seq;

    localparam logic [18:0] E0 = 19'h260E6;
    localparam logic [18:0] E1 = 19'h00001;
    localparam logic [18:0] E2 = 19'h7FFFF;

    logic clk;
    int   n_cmp;
    int   n_bad;

    // Instance A: wrapping 3-entry table
    logic        a_rst, a_cv, a_cr, a_clr, a_ov, a_or;
    logic [18:0] a_outs;
    logic [1:0]  a_idx;
    // Instance B: saturating 3-entry table
    logic        b_rst, b_cv, b_cr, b_clr, b_ov, b_or;
    logic [18:0] b_outs;
    logic [1:0]  b_idx;
    // Instance C: single-entry table
    logic        c_rst, c_cv, c_cr, c_clr, c_ov, c_or;
    logic [18:0] c_outs;
    logic [0:0]  c_idx;

    handshake_constant_seq #(
        .DATA_WIDTH(19), .DEPTH(3), .CONSTS({E2, E1, E0}), .WRAP(1)
    ) dut_a (
        .clk(clk), .rst(a_rst), .ctrl_valid(a_cv), .ctrl_ready(a_cr), .seq_clear(a_clr),
        .outs(a_outs), .outs_valid(a_ov), .outs_ready(a_or), .seq_idx(a_idx)
    );

    handshake_constant_seq #(
        .DATA_WIDTH(19), .DEPTH(3), .CONSTS({E2, E1, E0}), .WRAP(0)
    ) dut_b (
        .clk(clk), .rst(b_rst), .ctrl_valid(b_cv), .ctrl_ready(b_cr), .seq_clear(b_clr),
        .outs(b_outs), .outs_valid(b_ov), .outs_ready(b_or), .seq_idx(b_idx)
    );

    handshake_constant_seq #(
        .DATA_WIDTH(19), .DEPTH(1), .CONSTS(E0), .WRAP(1)
    ) dut_c (
        .clk(clk), .rst(c_rst), .ctrl_valid(c_cv), .ctrl_ready(c_cr), .seq_clear(c_clr),
        .outs(c_outs), .outs_valid(c_ov), .outs_ready(c_or), .seq_idx(c_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        rst;
        logic        cv;
        logic        ordy;
        logic        clr;
        logic        chk;
        logic        ov;
        logic [18:0] outs;
        logic        cr;
        logic [1:0]  idx;
    } vec_t;

    localparam int NVEC = 31;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic rst, cv, ordy, clr, chk, ov,
                                input logic [18:0] outs, input logic cr, input logic [1:0] idx);
        vec_t v;
        v.rst = rst; v.cv = cv; v.ordy = ordy; v.clr = clr; v.chk = chk;
        v.ov = ov; v.outs = outs; v.cr = cr; v.idx = idx;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    logic [18:0] sat_exp [5];
    logic [1:0]  sat_idx [6];
    int          occ, n_in, n_out;
    logic        cr_before;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        a_rst = 1'b0; a_cv = 1'b0; a_or = 1'b0; a_clr = 1'b0;
        b_rst = 1'b0; b_cv = 1'b0; b_or = 1'b0; b_clr = 1'b0;
        c_rst = 1'b0; c_cv = 1'b0; c_or = 1'b0; c_clr = 1'b0;

        // Each row: inputs for the cycle, and the outputs expected during that cycle.
        //              rst cv or clr chk ov outs cr idx
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, '0, 0, 0);
        // streaming after reset
        vecs[1]  = mk(1, 1, 1, 0, 1, 0, '0, 1, 0);
        vecs[2]  = mk(1, 1, 1, 0, 1, 1, E0, 1, 1);
        vecs[3]  = mk(1, 1, 1, 0, 1, 1, E1, 1, 2);
        vecs[4]  = mk(1, 1, 1, 0, 1, 1, E2, 1, 0);
        vecs[5]  = mk(1, 1, 1, 0, 1, 1, E0, 1, 1);
        vecs[6]  = mk(1, 1, 1, 0, 1, 1, E1, 1, 2);
        vecs[7]  = mk(1, 1, 1, 0, 1, 1, E2, 1, 0);
        vecs[8]  = mk(1, 0, 1, 0, 1, 1, E0, 1, 1);
        vecs[9]  = mk(1, 0, 0, 0, 1, 0, E0, 1, 1);
        // reset cycle: trigger offered but not accepted
        vecs[10] = mk(0, 1, 0, 0, 1, 0, E0, 0, 1);
        // backpressure: two accepted, third held until space frees
        vecs[11] = mk(1, 1, 0, 0, 1, 0, '0, 1, 0);
        vecs[12] = mk(1, 1, 0, 0, 1, 1, E0, 1, 1);
        vecs[13] = mk(1, 1, 0, 0, 1, 1, E0, 0, 2);
        vecs[14] = mk(1, 1, 0, 0, 1, 1, E0, 0, 2);
        vecs[15] = mk(1, 1, 1, 0, 1, 1, E0, 0, 2);
        vecs[16] = mk(1, 1, 1, 0, 1, 1, E1, 1, 2);
        vecs[17] = mk(1, 0, 1, 0, 1, 1, E2, 1, 0);
        vecs[18] = mk(1, 0, 1, 0, 1, 0, E2, 1, 0);
        // clear colliding with an accept at index 2
        vecs[19] = mk(1, 1, 1, 0, 1, 0, E2, 1, 0);
        vecs[20] = mk(1, 1, 1, 0, 1, 1, E0, 1, 1);
        vecs[21] = mk(1, 1, 1, 1, 1, 1, E1, 1, 2);
        vecs[22] = mk(1, 0, 1, 0, 1, 1, E0, 1, 1);
        vecs[23] = mk(1, 0, 1, 1, 1, 0, E0, 1, 1);
        vecs[24] = mk(1, 0, 1, 0, 1, 0, E0, 1, 0);
        // reset with both slots full
        vecs[25] = mk(1, 1, 0, 0, 1, 0, E0, 1, 0);
        vecs[26] = mk(1, 1, 0, 0, 1, 1, E0, 1, 1);
        vecs[27] = mk(0, 1, 0, 0, 1, 1, E0, 0, 2);
        vecs[28] = mk(1, 1, 1, 0, 1, 0, '0, 1, 0);
        vecs[29] = mk(1, 0, 1, 0, 1, 1, E0, 1, 1);
        vecs[30] = mk(1, 0, 1, 0, 1, 0, E0, 1, 1);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            a_rst = vecs[i].rst;
            a_cv  = vecs[i].cv;
            a_or  = vecs[i].ordy;
            a_clr = vecs[i].clr;
            #1;
            if (vecs[i].chk) begin
                check($sformatf("a_row%0d outs_valid", i), 32'(a_ov), 32'(vecs[i].ov));
                check($sformatf("a_row%0d outs", i), 32'(a_outs), 32'(vecs[i].outs));
                check($sformatf("a_row%0d ctrl_ready", i), 32'(a_cr), 32'(vecs[i].cr));
                check($sformatf("a_row%0d seq_idx", i), 32'(a_idx), 32'(vecs[i].idx));
            end
        end

        // Saturating table: five back-to-back triggers
        sat_exp[0] = E0; sat_exp[1] = E1; sat_exp[2] = E2; sat_exp[3] = E2; sat_exp[4] = E2;
        sat_idx[0] = 2'd0; sat_idx[1] = 2'd1; sat_idx[2] = 2'd2;
        sat_idx[3] = 2'd2; sat_idx[4] = 2'd2; sat_idx[5] = 2'd2;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            b_rst = 1'b1;
            b_cv  = (k < 5);
            b_or  = 1'b1;
            #1;
            if (k > 0) begin
                check($sformatf("sat_tok%0d outs_valid", k - 1), 32'(b_ov), 32'd1);
                check($sformatf("sat_tok%0d outs", k - 1), 32'(b_outs), 32'(sat_exp[k-1]));
            end
            check($sformatf("sat_cyc%0d seq_idx", k), 32'(b_idx), 32'(sat_idx[k]));
        end
        @(negedge clk);
        b_cv = 1'b0;
        #1;
        check("sat_final seq_idx", 32'(b_idx), 32'd2);

        // Single-entry table under random valid/ready against an occupancy model
        occ = 0; n_in = 0; n_out = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            c_rst = 1'b1;
            c_cv  = 1'($urandom_range(0, 1));
            c_or  = 1'($urandom_range(0, 1));
            #1;
            check("deg ctrl_ready", 32'(c_cr), 32'(occ < 2));
            check("deg outs_valid", 32'(c_ov), 32'(occ > 0));
            check("deg seq_idx", 32'(c_idx), 32'd0);
            cr_before = c_cr;
            c_or = ~c_or;
            #1;
            check("deg ready_indep", 32'(c_cr), 32'(cr_before));
            c_or = ~c_or;
            #1;
            if (c_ov && c_or) begin
                check("deg token", 32'(c_outs), 32'(E0));
                n_out++;
                occ--;
            end
            if (c_cv && c_cr) begin
                n_in++;
                occ++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            c_cv = 1'b0;
            c_or = 1'b1;
            #1;
            if (c_ov && c_or) begin
                check("deg drain token", 32'(c_outs), 32'(E0));
                n_out++;
                occ--;
            end
        end
        check("deg count in/out", 32'(n_out), 32'(n_in));
        check("deg final valid", 32'(c_ov), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
